muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle integer multiply/divide unit for the execute stage of the pipelined MIPS core. It implements MULT, MULTU, DIV and DIVU with its own internal adder/subtractor instead of borrowing the main ALU, and holds the architectural HI/LO registers. It handles MTHI/MTLO writes and supports a pipeline flush. The hazard unit stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits. Legal range: 4 to 64.
- `CNT_W`, default `$clog2(WIDTH+1)`: iteration counter width. Derived; do not override.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  launches the operation in `op` using `src_a` and `src_b`. Accepted only when idle.
- `op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `src_a`  in  WIDTH  multiplicand or dividend.
- `src_b`  in  WIDTH  multiplier or divisor.
- `flush`  in  1  synchronous abort of an in-flight operation.
- `mthi`, `mtlo`  in  1 each  write `wdata` into HI or LO.
- `wdata`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO have just been updated by an operation.
- `div_by_zero`  out  1  pulses together with `done` for a divide whose divisor is 0.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- State machine with states IDLE, RUN and FIX.
- **IDLE to RUN:** on `start` (and `flush` low), the unit latches `op`, the magnitudes |src_a| and |src_b|, and the result sign bits, then clears the counter.
  - Magnitudes apply to signed ops only; unsigned ops use the raw operands.
  - Quotient/product sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- **RUN:** one iteration per cycle for `WIDTH` cycles, then go to FIX.
  - Multiply: radix-2 shift-add over a 2·WIDTH product register. If the LSB is 1, add the multiplicand to the upper half (WIDTH+1-bit sum), then shift the whole register right by 1.
  - Divide: restoring division. Shift the {remainder, quotient} register left by 1, trial-subtract the divisor using a WIDTH+1-bit subtract, and keep the result if it is non-negative, setting the quotient bit.
- **FIX:** apply sign correction (two's-complement negate where the sign bits require it), write HI/LO, pulse `done`, return to IDLE.
  - MULT/MULTU: HI = upper half, LO = lower half of the product.
  - DIV/DIVU: LO = quotient, HI = remainder.
- **Divide by zero:** runs the full latency. Result is HI = original `src_a`, LO = all ones, and `div_by_zero` = 1.
- **Signed overflow:** DIV of the most-negative value by −1 gives LO = most-negative value, HI = 0. This falls out naturally from wrap-around of the magnitude arithmetic.
- **flush** in RUN or FIX: return to IDLE on that edge with no HI/LO write and no `done`. A `flush` in IDLE suppresses a simultaneous `start`.
- **mthi/mtlo:** honoured only in IDLE, and only when `start` is low; `start` has priority. Ignored while `busy` is high.
- **Signal levels:**
  - `busy` = 1 in RUN and FIX.
  - `start` while busy is ignored.
- **Reset** (any time, including mid-operation): state IDLE; `busy`, `done`, `div_by_zero` = 0; `hi`, `lo` = 0; internal registers cleared.

## Timing
- Edge E0 samples `start`; `busy` is high after E0.
- Edges E1..E_WIDTH perform the iterations.
- Edge E_(WIDTH+1) (FIX) writes HI/LO and sets `done`; `busy` falls after it.
- Results are visible `WIDTH+1` cycles after the start edge: 33 cycles for WIDTH = 32.
- `done` and `div_by_zero` are high for exactly one cycle. A new `start` is accepted in the cycle `done` is high.
- MTHI/MTLO: HI/LO update on the sampling edge, giving one-cycle latency.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `muldiv_pkg`:
  - op encodings `OP_MULTU`, `OP_MULT`, `OP_DIVU`, `OP_DIV`;
  - state enum IDLE/RUN/FIX.
- Sub-module `muldiv_addsub`: parametrised WIDTH+1-bit adder/subtractor with a `sub` select, shared by the multiply and divide datapaths.
- The FSM, counter and shift registers live in `muldiv_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles HI = 0xFFFFFFFE, LO = 0x00000001, `done` high for 1 cycle.
- MULT −3 × 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 -> HI = 0x00000064, LO = 0xFFFFFFFF, `div_by_zero` = 1 with `done`. DIV 0x80000000 / −1 -> LO = 0x80000000, HI = 0.
- MTHI 0x1234 in IDLE -> HI = 0x1234 the next cycle. During `busy`: `mtlo` and a second `start` are ignored, LO unchanged, and the first result is correct.
- `flush` at cycle 10 of a MULT -> `busy` = 0 next cycle, HI/LO keep their prior values, no `done`. Assert `rst` mid-operation -> all outputs 0 immediately.
- WIDTH = 8 instance: MULT 0x80 × 0x80 -> HI = 0x40, LO = 0x00 after 9 cycles. Random signed/unsigned sweep checked against a reference model.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared operation encodings and state type for the multiply/divide unit.
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: (WIDTH+1)-bit adder/subtractor; cout is the carry, i.e. "no borrow" when subtracting.
`default_nettype none

module muldiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] y,
  output logic           cout
);

  logic [WIDTH+1:0] full;

  assign full = {1'b0, a} + {1'b0, b ^ {(WIDTH+1){sub}}} + {{(WIDTH+1){1'b0}}, sub};
  assign y    = full[WIDTH:0];
  assign cout = full[WIDTH+1];

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO, MTHI/MTLO and flush.
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t               state, state_nxt;
  logic                 div_q;
  logic                 neg_q;
  logic                 neg_r;
  logic                 b_zero;
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     a_raw;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;

  logic                 sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       as_a, as_b, as_y;
  logic                 as_sub, as_c;
  logic [2*WIDTH-1:0]   acc_iter;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo, rem;
  logic [WIDTH-1:0]     hi_fix, lo_fix;
  logic                 accept;

  assign accept = (state == IDLE) && start && !flush;
  assign busy   = (state != IDLE);

  assign sa    = op[0] && src_a[WIDTH-1];
  assign sb    = op[0] && src_b[WIDTH-1];
  assign mag_a = sa ? -src_a : src_a;
  assign mag_b = sb ? -src_b : src_b;

  // Multiply adds the multiplicand into the upper half; divide trial-subtracts
  // the divisor from the shifted remainder including the bit shifted out.
  always_comb begin
    as_a   = '0;
    as_b   = '0;
    as_sub = 1'b0;
    if (div_q) begin
      as_a   = acc[2*WIDTH-1:WIDTH-1];
      as_b   = {1'b0, opnd};
      as_sub = 1'b1;
    end else begin
      as_a   = {1'b0, acc[2*WIDTH-1:WIDTH]};
      as_b   = acc[0] ? {1'b0, opnd} : '0;
      as_sub = 1'b0;
    end
  end

  muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .y    (as_y),
    .cout (as_c)
  );

  always_comb begin
    acc_iter = acc;
    if (div_q) begin
      if (as_c)
        acc_iter = {as_y[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_iter = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_iter = {as_y, acc[WIDTH-1:1]};
    end
  end

  assign prod_fix = neg_q ? -acc : acc;
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    hi_fix = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (b_zero) begin
        hi_fix = a_raw;
        lo_fix = '1;
      end else begin
        hi_fix = neg_r ? -rem : rem;
        lo_fix = neg_q ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN: begin
        if (flush)                           state_nxt = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      opnd        <= '0;
      a_raw       <= '0;
      acc         <= '0;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            div_q  <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            b_zero <= (src_b == '0);
            a_raw  <= src_a;
            cnt    <= '0;
            if (op[1]) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end else if (!start) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          if (!flush) begin
            acc <= acc_iter;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            hi          <= hi_fix;
            lo          <= lo_fix;
            done        <= 1'b1;
            div_by_zero <= div_q && b_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit at WIDTH=32 and WIDTH=8.
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;

  logic        start, flush, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  logic        s_start, s_flush, s_mthi, s_mtlo;
  logic [1:0]  s_op;
  logic [7:0]  s_src_a, s_src_b, s_wdata;
  logic        s_busy, s_done, s_div_by_zero;
  logic [7:0]  s_hi, s_lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy),
    .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .op(s_op), .src_a(s_src_a), .src_b(s_src_b),
    .flush(s_flush), .mthi(s_mthi), .mtlo(s_mtlo), .wdata(s_wdata), .busy(s_busy),
    .done(s_done), .div_by_zero(s_div_by_zero), .hi(s_hi), .lo(s_lo)
  );

  // Reference: exact integer arithmetic in 64 bits, then truncated to the unit width.
  function automatic void model(input int w, input logic [1:0] o, input logic [63:0] a_in,
                                input logic [63:0] b_in, output logic [63:0] mh,
                                output logic [63:0] ml, output logic mz);
    logic [63:0] mask, a, b, sa, sb, p;
    longint q, r;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sa = a;
    sb = b;
    if (o[0]) begin
      if (a[w-1]) sa = a | ~mask;
      if (b[w-1]) sb = b | ~mask;
    end
    mz = 1'b0;
    mh = '0;
    ml = '0;
    if (!o[1]) begin
      p  = sa * sb;
      ml = p & mask;
      mh = (p >> w) & mask;
    end else if (b == 64'd0) begin
      mh = a;
      ml = mask;
      mz = 1'b1;
    end else begin
      if (o[0]) begin
        q = $signed(sa) / $signed(sb);
        r = $signed(sa) % $signed(sb);
      end else begin
        q = longint'(a / b);
        r = longint'(a % b);
      end
      ml = q & mask;
      mh = r & mask;
    end
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask, v;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = mask;
      2:       v = 64'd1 << (w - 1);
      3:       v = 64'd1;
      default: v = {$urandom(), $urandom()};
    endcase
    return v & mask;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or timeout).
  task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busy_seen);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    busy_seen = busy;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                      output int lat, output logic busy_seen);
    s_start = 1'b1; s_op = o; s_src_a = a; s_src_b = b;
    @(negedge clk);
    s_start = 1'b0;
    busy_seen = s_busy;
    lat = 0;
    while (!s_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
      failures++;
      $display("FAIL reset32 got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0", busy, done, div_by_zero, hi, lo);
    end
    checks++;
    if ({s_busy, s_done, s_div_by_zero, s_hi, s_lo} !== 19'd0) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0", s_busy, s_done, s_div_by_zero, s_hi, s_lo);
    end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [6]  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
    logic [31:0] as  [6]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd17};
    logic [31:0] bs  [6]  = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB};
    logic [31:0] eh  [6]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h64, 32'h0, 32'h2};
    logic [31:0] el  [6]  = '{32'h1, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD};
    logic        ez  [6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    logic bz;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run32(ops[i], as[i], bs[i], lat, bz);
      checks++;
      if (!bz) begin
        failures++; $display("FAIL dir%0d_busy got %b want 1", i, bz);
      end
      checks++;
      if (lat != 33) begin
        failures++; $display("FAIL dir%0d_latency got %0d want 33", i, lat);
      end
      checks++;
      if (hi !== eh[i] || lo !== el[i] || div_by_zero !== ez[i]) begin
        failures++;
        $display("FAIL dir%0d_result got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                 i, hi, lo, div_by_zero, eh[i], el[i], ez[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_pulse got done=%b dbz=%b busy=%b want 0 0 0", i, done, div_by_zero, busy);
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h1234) begin
      failures++; $display("FAIL mthi got %h want 00001234", hi);
    end
    mtlo = 1'b1; wdata = 32'h5555;
    @(negedge clk);
    mtlo = 1'b0;
    checks++;
    if (lo !== 32'h5555 || hi !== 32'h1234) begin
      failures++; $display("FAIL mtlo got hi=%h lo=%h want 00001234 00005555", hi, lo);
    end
    // start has priority over a simultaneous mtlo
    mtlo = 1'b1; wdata = 32'hBAD0; start = 1'b1; flush = 1'b1; op = 2'b00;
    @(negedge clk);
    mtlo = 1'b0; start = 1'b0; flush = 1'b0;
    checks++;
    if (lo !== 32'h5555 || busy !== 1'b0) begin
      failures++; $display("FAIL mtlo_vs_start got lo=%h busy=%b want 00005555 0", lo, busy);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    start = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    mtlo = 1'b1; wdata = 32'hDEAD; start = 1'b1; op = 2'b10; src_a = 32'd1; src_b = 32'd1;
    @(negedge clk);
    mtlo = 1'b0; start = 1'b0; src_a = 32'hFFFF; src_b = 32'hFFFF;
    checks++;
    if (lo !== 32'h5555) begin
      failures++; $display("FAIL busy_mtlo got lo=%h want 00005555", lo);
    end
    lat = 5;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 33 || hi !== 32'd0 || lo !== 32'd63) begin
      failures++; $display("FAIL busy_result got lat=%0d hi=%h lo=%h want 33 0 3f", lat, hi, lo);
    end
  endtask

  task automatic test_flush();
    int ndone;
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA1111;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    start = 1'b1; op = 2'b01; src_a = 32'hFFFFFFFD; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL flush_busy got %b want 0", busy);
    end
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || hi !== 32'hAAAA1111 || lo !== 32'hAAAA1111) begin
      failures++; $display("FAIL flush_hold got done_count=%0d hi=%h lo=%h want 0 aaaa1111 aaaa1111", ndone, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bz;
    logic [63:0] mh, ml;
    logic mz;
    @(negedge clk);
    run32(2'b01, 32'd1000, 32'hFFFFFFFE, lat, bz);
    model(32, 2'b01, 64'd1000, 64'hFFFFFFFE, mh, ml, mz);
    checks++;
    if (hi !== mh[31:0] || lo !== ml[31:0]) begin
      failures++; $display("FAIL b2b_first got hi=%h lo=%h want %h %h", hi, lo, mh[31:0], ml[31:0]);
    end
    run32(2'b11, 32'h7FFFFFFF, 32'd10, lat, bz);
    model(32, 2'b11, 64'h7FFFFFFF, 64'd10, mh, ml, mz);
    checks++;
    if (!bz || lat != 33 || hi !== mh[31:0] || lo !== ml[31:0]) begin
      failures++; $display("FAIL b2b_second got busy=%b lat=%0d hi=%h lo=%h want 1 33 %h %h",
                           bz, lat, hi, lo, mh[31:0], ml[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'hFFFFFF00; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
      failures++; $display("FAIL reset_mid got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0", busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_width8();
    int lat;
    logic bz;
    @(negedge clk);
    run8(2'b01, 8'h80, 8'h80, lat, bz);
    checks++;
    if (!bz || lat != 9 || s_hi !== 8'h40 || s_lo !== 8'h00) begin
      failures++; $display("FAIL w8_mult got busy=%b lat=%0d hi=%h lo=%h want 1 9 40 00", bz, lat, s_hi, s_lo);
    end
    @(negedge clk);
    run8(2'b11, 8'h80, 8'hFF, lat, bz);
    checks++;
    if (s_hi !== 8'h00 || s_lo !== 8'h80 || s_div_by_zero !== 1'b0) begin
      failures++; $display("FAIL w8_ovf got hi=%h lo=%h dbz=%b want 00 80 0", s_hi, s_lo, s_div_by_zero);
    end
  endtask

  task automatic test_random();
    int lat;
    logic bz, mz;
    logic [1:0] o;
    logic [63:0] a, b, mh, ml;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick(32);
      b = pick(32);
      model(32, o, a, b, mh, ml, mz);
      @(negedge clk);
      run32(o, a[31:0], b[31:0], lat, bz);
      checks++;
      if (lat != 33 || hi !== mh[31:0] || lo !== ml[31:0] || div_by_zero !== mz) begin
        failures++;
        $display("FAIL rnd32_%0d op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h dbz=%b want 33 %h %h %b",
                 i, o, a[31:0], b[31:0], lat, hi, lo, div_by_zero, mh[31:0], ml[31:0], mz);
      end
    end
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick(8);
      b = pick(8);
      model(8, o, a, b, mh, ml, mz);
      @(negedge clk);
      run8(o, a[7:0], b[7:0], lat, bz);
      checks++;
      if (lat != 9 || s_hi !== mh[7:0] || s_lo !== ml[7:0] || s_div_by_zero !== mz) begin
        failures++;
        $display("FAIL rnd8_%0d op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h dbz=%b want 9 %h %h %b",
                 i, o, a[7:0], b[7:0], lat, s_hi, s_lo, s_div_by_zero, mh[7:0], ml[7:0], mz);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00;
    src_a = '0; src_b = '0; wdata = '0;
    s_start = 1'b0; s_flush = 1'b0; s_mthi = 1'b0; s_mtlo = 1'b0; s_op = 2'b00;
    s_src_a = '0; s_src_b = '0; s_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_directed();
    test_mthi_mtlo();
    test_busy_ignore();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
